axis_pack_output: RTL and testbench

- Accumulation/emission stage directly downstream of the stream packer input stage.
- Consumes per-beat sparse byte lanes with exclusive prefix byte offsets, total count, byte valids and last. Compacts the valid bytes onto a residual byte buffer.
- Emits dense AXI-Stream words: full words mid-packet, a partial tkeep word at packet end.
- Generates the input_pause / output_pause backpressure signals that gate the input stage's FIFO read.

---
 rtl/stream_packer_pkg.sv | 23 ++
 rtl/axis_pack_output_if.sv | 22 ++
 rtl/pack_byte_place.sv | 31 +++
 rtl/axis_pack_output.sv | 162 ++++++++++++++++
 tb/tb_axis_pack_output.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_packer_pkg.sv
// Shared types and helpers for the stream packer output stage.
package stream_packer_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    TAIL  = 1'b1
  } pack_out_state_t;

  localparam int unsigned KEEP_MAX = 64;

  // Low-aligned keep mask with n ones; callers truncate to their lane count.
  function automatic logic [KEEP_MAX-1:0] keep_from_count(input int unsigned n);
    logic [KEEP_MAX-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (i < n) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_pack_output_if.sv
// Packed AXI-Stream output bus of the stream packer.
interface axis_pack_output_if #(
  parameter int unsigned DWIDTH_OUT = 32
);
  localparam int unsigned N_BYTES_OUT = DWIDTH_OUT / 8;

  logic [DWIDTH_OUT-1:0]  packed_tdata;
  logic [N_BYTES_OUT-1:0] packed_tkeep;
  logic                   packed_tlast;
  logic                   packed_tvalid;
  logic                   packed_tready;

  modport master (
    output packed_tdata, packed_tkeep, packed_tlast, packed_tvalid,
    input  packed_tready
  );

  modport slave (
    input  packed_tdata, packed_tkeep, packed_tlast, packed_tvalid,
    output packed_tready
  );
endinterface

// File: rtl/pack_byte_place.sv
// Scatters valid input lanes to residual positions r + in_bytes[i], merged over the residual.
module pack_byte_place
  import stream_packer_pkg::*;
#(
  parameter int unsigned N_BYTES_IN  = 4,
  parameter int unsigned N_BYTES_OUT = 4,
  parameter int unsigned C_IN        = 3,
  parameter int unsigned C_ACC       = 3
) (
  input  byte_t [N_BYTES_IN-1:0]            in_data,
  input  logic  [N_BYTES_IN-1:0][C_IN-1:0]  in_bytes,
  input  logic  [N_BYTES_IN-1:0]            in_valid,
  input  logic  [C_ACC-1:0]                 r,
  input  byte_t [2*N_BYTES_OUT-1:0]         resid,
  output byte_t [2*N_BYTES_OUT-1:0]         merged
);

  localparam int unsigned N_BUF = 2 * N_BYTES_OUT;

  logic [N_BYTES_IN-1:0][C_ACC-1:0] pos;

  always_comb begin
    merged = resid;
    pos    = '0;
    for (int unsigned i = 0; i < N_BYTES_IN; i++) begin
      pos[i] = r + C_ACC'(in_bytes[i]);
      if (in_valid[i] && (32'(pos[i]) < N_BUF)) merged[pos[i]] = in_data[i];
    end
  end

endmodule

// File: rtl/axis_pack_output.sv
// Residual byte accumulator and dense AXI-Stream emitter of the stream packer.
// STREAM_PACKER_ZLP_EN: an accepted empty last beat emits a zero-length tlast beat.
module axis_pack_output
  import stream_packer_pkg::*;
#(
  parameter  int unsigned DWIDTH_IN   = 32,
  parameter  int unsigned DWIDTH_OUT  = 32,
  localparam int unsigned N_BYTES_IN  = DWIDTH_IN / 8,
  localparam int unsigned N_BYTES_OUT = DWIDTH_OUT / 8,
  localparam int unsigned C_IN        = $clog2(N_BYTES_IN + 1),
  localparam int unsigned C_ACC       = $clog2(2 * N_BYTES_OUT)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  byte_t [N_BYTES_IN-1:0]          in_data,
  input  logic  [N_BYTES_IN-1:0][C_IN-1:0] in_bytes,
  input  logic  [C_IN-1:0]                in_total_bytes,
  input  logic  [N_BYTES_IN-1:0]          in_valid,
  input  logic                            in_last,
  output logic                            input_pause,
  output logic                            output_pause,
  axis_pack_output_if.master              pack_out
);

  localparam int unsigned N_BUF = 2 * N_BYTES_OUT;
  localparam logic [C_ACC-1:0] N_OUT = C_ACC'(N_BYTES_OUT);

  pack_out_state_t state, state_nxt;
  logic [C_ACC-1:0] r, r_nxt, s, emit_cnt;
  byte_t [N_BUF-1:0] resid, resid_nxt, merged, src;
  byte_t [N_BYTES_OUT-1:0] tdata_q, tdata_nxt;
  logic [N_BYTES_OUT-1:0] tkeep_q, tkeep_nxt;
  logic tlast_q, tlast_nxt, tvalid_q, tvalid_nxt;
  logic out_free, accept, emit, emit_last, shift;

  pack_byte_place #(
    .N_BYTES_IN (N_BYTES_IN),
    .N_BYTES_OUT(N_BYTES_OUT),
    .C_IN       (C_IN),
    .C_ACC      (C_ACC)
  ) u_place (
    .in_data (in_data),
    .in_bytes(in_bytes),
    .in_valid(in_valid),
    .r       (r),
    .resid   (resid),
    .merged  (merged)
  );

  assign out_free     = ~tvalid_q | pack_out.packed_tready;
  assign output_pause = ~out_free;
  assign input_pause  = (state == TAIL);
  assign accept       = ((|in_valid) | in_last) & (state == ACCUM) & out_free;
  assign s            = r + C_ACC'(in_total_bytes);

  assign pack_out.packed_tdata  = tdata_q;
  assign pack_out.packed_tkeep  = tkeep_q;
  assign pack_out.packed_tlast  = tlast_q;
  assign pack_out.packed_tvalid = tvalid_q;

  // Next-state, residual update and output-register load.
  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    resid_nxt = resid;
    emit      = 1'b0;
    emit_cnt  = '0;
    emit_last = 1'b0;
    shift     = 1'b0;
    src       = merged;
    unique case (state)
      ACCUM: begin
        if (accept) begin
          if (!in_last) begin
            if (s < N_OUT) begin
              r_nxt     = s;
              resid_nxt = merged;
            end else begin
              emit     = 1'b1;
              emit_cnt = N_OUT;
              shift    = 1'b1;
              r_nxt    = s - N_OUT;
            end
          end else if (s == '0) begin
`ifdef STREAM_PACKER_ZLP_EN
            emit      = 1'b1;
            emit_last = 1'b1;
`endif
            r_nxt     = '0;
            resid_nxt = '0;
          end else if (s <= N_OUT) begin
            emit      = 1'b1;
            emit_cnt  = s;
            emit_last = 1'b1;
            r_nxt     = '0;
            resid_nxt = '0;
          end else begin
            emit      = 1'b1;
            emit_cnt  = N_OUT;
            shift     = 1'b1;
            r_nxt     = s - N_OUT;
            state_nxt = TAIL;
          end
        end
      end
      TAIL: begin
        // The input beat is held during the flush, so drain from the stored residual only.
        src = resid;
        if (out_free) begin
          emit      = 1'b1;
          emit_cnt  = r;
          emit_last = 1'b1;
          r_nxt     = '0;
          resid_nxt = '0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase

    if (shift) begin
      for (int unsigned b = 0; b < N_BYTES_OUT; b++) begin
        resid_nxt[b]               = merged[b + N_BYTES_OUT];
        resid_nxt[b + N_BYTES_OUT] = '0;
      end
    end

    tvalid_nxt = tvalid_q & ~pack_out.packed_tready;
    tdata_nxt  = tdata_q;
    tkeep_nxt  = tkeep_q;
    tlast_nxt  = tlast_q;
    if (emit) begin
      tvalid_nxt = 1'b1;
      tlast_nxt  = emit_last;
      tkeep_nxt  = N_BYTES_OUT'(keep_from_count(32'(emit_cnt)));
      for (int unsigned b = 0; b < N_BYTES_OUT; b++) begin
        tdata_nxt[b] = tkeep_nxt[b] ? src[b] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      r        <= '0;
      resid    <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      r        <= r_nxt;
      resid    <= resid_nxt;
      tdata_q  <= tdata_nxt;
      tkeep_q  <= tkeep_nxt;
      tlast_q  <= tlast_nxt;
      tvalid_q <= tvalid_nxt;
    end
  end

endmodule

// File: tb/tb_axis_pack_output.sv
// Self-checking bench for axis_pack_output: byte-queue model plus directed literal checks.
module tb_axis_pack_output;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0][7:0] in_data;
  logic [3:0][2:0] in_bytes;
  logic [2:0]      in_total_bytes;
  logic [3:0]      in_valid;
  logic            in_last;
  logic            input_pause, output_pause;

  int ncmp = 0;
  int nfail = 0;
  int pcnt = 0;
  int ocnt = 0;
  bit rand_mode = 1'b0;
  bit ready_val = 1'b1;

  beat_t exp_q[$];
  beat_t obs_q[$];
  logic [7:0] mq[$];

  axis_pack_output_if #(.DWIDTH_OUT(32)) pif ();

  axis_pack_output #(.DWIDTH_IN(32), .DWIDTH_OUT(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_bytes      (in_bytes),
    .in_total_bytes(in_total_bytes),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .input_pause   (input_pause),
    .output_pause  (output_pause),
    .pack_out      (pif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    pif.packed_tready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_val;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (input_pause) pcnt = pcnt + 1;
      if (output_pause) ocnt = ocnt + 1;
    end
  end

  // Reference: bytes queue in order; words leave at the beat boundaries the stage defines.
  function automatic beat_t pop_word(input int n, input logic last);
    beat_t w;
    w.d = '0;
    w.k = '0;
    w.l = last;
    for (int b = 0; b < n; b++) begin
      w.d[8*b +: 8] = mq.pop_front();
      w.k[b] = 1'b1;
    end
    return w;
  endfunction

  function automatic void model_beat(input logic [31:0] d, input logic [3:0] v, input logic last);
    beat_t z;
    for (int i = 0; i < 4; i++) if (v[i]) mq.push_back(d[8*i +: 8]);
    if (!last) begin
      if (mq.size() >= 4) exp_q.push_back(pop_word(4, 1'b0));
    end else begin
      while (mq.size() > 4) exp_q.push_back(pop_word(4, 1'b0));
      if (mq.size() > 0) exp_q.push_back(pop_word(mq.size(), 1'b1));
      else begin
        z.d = '0; z.k = '0; z.l = 1'b1;
`ifdef STREAM_PACKER_ZLP_EN
        exp_q.push_back(z);
`endif
      end
    end
  endfunction

  // Output compare and hold-stability check.
  initial begin
    bit prev_stall;
    beat_t pd, got, e;
    prev_stall = 1'b0;
    pd = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 1'b0;
      else begin
        got.d = pif.packed_tdata;
        got.k = pif.packed_tkeep;
        got.l = pif.packed_tlast;
        if (prev_stall) begin
          ncmp = ncmp + 1;
          if (!pif.packed_tvalid || got.d !== pd.d || got.k !== pd.k || got.l !== pd.l) begin
            nfail = nfail + 1;
            $display("FAIL hold: got v=%0b d=%h k=%h l=%0b, required v=1 d=%h k=%h l=%0b",
                     pif.packed_tvalid, got.d, got.k, got.l, pd.d, pd.k, pd.l);
          end
        end
        if (pif.packed_tvalid && pif.packed_tready) begin
          ncmp = ncmp + 1;
          obs_q.push_back(got);
          if (exp_q.size() == 0) begin
            nfail = nfail + 1;
            $display("FAIL beat: unexpected d=%h k=%h l=%0b, required none", got.d, got.k, got.l);
          end else begin
            e = exp_q.pop_front();
            if (got.d !== e.d || got.k !== e.k || got.l !== e.l) begin
              nfail = nfail + 1;
              $display("FAIL beat: got d=%h k=%h l=%0b, required d=%h k=%h l=%0b",
                       got.d, got.k, got.l, e.d, e.k, e.l);
            end
          end
        end
        prev_stall = pif.packed_tvalid && !pif.packed_tready;
        pd = got;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    ncmp = ncmp + 1;
    if (got !== want) begin
      nfail = nfail + 1;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  task automatic check_obs(input string name, input int idx, input logic [31:0] d,
                           input logic [3:0] k, input logic l);
    if (idx >= obs_q.size()) begin
      ncmp = ncmp + 1;
      nfail = nfail + 1;
      $display("FAIL %s: no observed beat %0d, required d=%h k=%h l=%0b", name, idx, d, k, l);
    end else begin
      check(name, {obs_q[idx].d, obs_q[idx].k, obs_q[idx].l}, {d, k, l});
    end
  endtask

  task automatic set_idle();
    in_data = '0;
    in_bytes = '0;
    in_total_bytes = '0;
    in_valid = '0;
    in_last = 1'b0;
  endtask

  // Present one beat until the stage accepts it; called just after a rising edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] v, input logic last);
    int cnt;
    bit done;
    cnt = 0;
    in_data = d;
    for (int i = 0; i < 4; i++) begin
      in_bytes[i] = 3'(cnt);
      if (v[i]) cnt++;
    end
    in_total_bytes = 3'(cnt);
    in_valid = v;
    in_last = last;
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (!input_pause && !output_pause) begin
        model_beat(d, v, last);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    set_idle();
    if (!done) begin
      ncmp = ncmp + 1;
      nfail = nfail + 1;
      $display("FAIL accept_timeout: beat %h not accepted, required acceptance", d);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 500 && (exp_q.size() != 0 || pif.packed_tvalid)) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 500) begin
      ncmp = ncmp + 1;
      nfail = nfail + 1;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, p0, o0, nb;
    logic [3:0] v;
    set_idle();
    rst_n = 1'b1;
    ready_val = 1'b1;
    #2 rst_n = 1'b0;
    #21;
    check("rst_tvalid", 64'(pif.packed_tvalid), 64'd0);
    check("rst_tdata", 64'(pif.packed_tdata), 64'd0);
    check("rst_tkeep", 64'(pif.packed_tkeep), 64'd0);
    check("rst_tlast", 64'(pif.packed_tlast), 64'd0);
    check("rst_input_pause", 64'(input_pause), 64'd0);
    check("rst_output_pause", 64'(output_pause), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two full beats, no tail.
    base = obs_q.size(); p0 = pcnt;
    send_beat(32'h44332211, 4'hF, 1'b0);
    send_beat(32'h88776655, 4'hF, 1'b1);
    drain();
    check("t1_count", 64'(obs_q.size() - base), 64'd2);
    check_obs("t1_w0", base, 32'h44332211, 4'hF, 1'b0);
    check_obs("t1_w1", base + 1, 32'h88776655, 4'hF, 1'b1);
    check("t1_input_pause", 64'(pcnt - p0), 64'd0);

    // Sparse lanes compacted into one word.
    base = obs_q.size();
    send_beat(32'h44332211, 4'h5, 1'b0);
    send_beat(32'h88776655, 4'hA, 1'b1);
    drain();
    check("t2_count", 64'(obs_q.size() - base), 64'd1);
    check_obs("t2_w0", base, 32'h88663311, 4'hF, 1'b1);

    // Overflow on last beat forces a tail flush.
    base = obs_q.size(); p0 = pcnt;
    send_beat(32'h00332211, 4'h7, 1'b0);
    send_beat(32'hDDCCBBAA, 4'hF, 1'b1);
    drain();
    check("t3_count", 64'(obs_q.size() - base), 64'd2);
    check_obs("t3_w0", base, 32'hAA332211, 4'hF, 1'b0);
    check_obs("t3_w1", base + 1, 32'h00DDCCBB, 4'h7, 1'b1);
    check("t3_input_pause", 64'(pcnt - p0), 64'd1);

    // Downstream stall for 5 cycles.
    base = obs_q.size();
    ready_val = 1'b0;
    send_beat(32'h04030201, 4'hF, 1'b0);
    o0 = ocnt;
    fork
      send_beat(32'h08070605, 4'hF, 1'b1);
      begin
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        check("t4_output_pause", 64'(ocnt - o0), 64'd5);
        ready_val = 1'b1;
      end
    join
    drain();
    check("t4_count", 64'(obs_q.size() - base), 64'd2);
    check_obs("t4_w0", base, 32'h04030201, 4'hF, 1'b0);
    check_obs("t4_w1", base + 1, 32'h08070605, 4'hF, 1'b1);

    // Empty last beat with nothing buffered.
    base = obs_q.size();
    send_beat(32'h12345678, 4'h0, 1'b1);
    drain();
`ifdef STREAM_PACKER_ZLP_EN
    check("t5_count", 64'(obs_q.size() - base), 64'd1);
    check_obs("t5_zlp", base, 32'h0, 4'h0, 1'b1);
`else
    check("t5_count", 64'(obs_q.size() - base), 64'd0);
`endif
    base = obs_q.size();
    send_beat(32'h5566BBAA, 4'h3, 1'b1);
    drain();
    check_obs("t5_after", base, 32'h0000BBAA, 4'h3, 1'b1);

    // Async reset with residual bytes and a pending output word.
    ready_val = 1'b0;
    send_beat(32'h00002211, 4'h3, 1'b0);
    send_beat(32'h66554433, 4'hF, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(pif.packed_tvalid), 64'd0);
    check("t6_rst_tkeep", 64'(pif.packed_tkeep), 64'd0);
    exp_q.delete();
    mq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_val = 1'b1;
    @(posedge clk);
    #1;
    base = obs_q.size();
    send_beat(32'h4D3C2B1A, 4'hF, 1'b1);
    drain();
    check("t6_count", 64'(obs_q.size() - base), 64'd1);
    check_obs("t6_w0", base, 32'h4D3C2B1A, 4'hF, 1'b1);

    // Randomised packets with random backpressure and gaps.
    rand_mode = 1'b1;
    for (int p = 0; p < 250; p++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        v = (b == nb - 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15));
        send_beat($urandom, v, b == nb - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_mode = 1'b0;
    ready_val = 1'b1;
    drain();
    check("rand_outstanding", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
